// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester arbiter for the single byte-wide memory port shared by the
// WASM ROM parser (requester 0) and the CPU (requester 1).
//
// One requester at a time owns the memory. Its gntN output drives that
// requester's mem_access input. While it owns the bus, its address, write
// data and enables are forwarded to the memory, and mem_ready is returned to
// it alone.
//
// A burst keeps ownership until either of these happens:
//   - the owner drops its request, or
//   - the other requester has waited long enough (MAX_HOLD owned cycles).
// Neither release can happen while a read is still in flight.
//
// Every handover passes through one dead cycle in which no grant and no
// memory enable is active.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   req0/req1               : bus requests, held for the whole burst
//   gnt0/gnt1               : registered grants (requester mem_access)
//   addr0/1, wdata0/1       : requester address / write data
//   rd_en0/1, wr_en0/1      : requester read (held to ready) / write pulse
//   ready0/1                : mem_ready gated to the current owner
//   rdata                   : mem_data_out broadcast to both requesters
//   mem_addr, mem_data_in   : memory address / write data
//   mem_read_en, mem_write_en : memory enables
//   mem_data_out, mem_ready : memory response
//   violation               : sticky protocol-error flag, cleared by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,

  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rd_en0,
  input  logic              rd_en1,
  input  logic              wr_en0,
  input  logic              wr_en1,
  output logic              ready0,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,

  output logic              violation
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // The owner may be preempted once hold reaches this value. hold counts
  // the owned cycles that came before the current one, so this value gives
  // MAX_HOLD owned cycles in total.
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state;
  logic       owner;
  logic       last;
  logic [7:0] hold;

  logic own_req;
  logic oth_req;
  logic own_rd;
  logic in_flight;
  logic release_ok;
  logic win;
  logic bad;

  // Winner when ownership is free. A lone request wins outright. On a tie,
  // the requester that did not own the bus most recently wins. The same rule
  // covers both the IDLE and the TURN cycle: in TURN, last is the previous
  // owner, so the waiting requester is preferred and the previous owner is
  // taken only if it is the sole requester.
  function automatic logic pick(input logic r0, input logic r1,
                                input logic prev);
    logic sel;
    if (r0 && r1) begin
      sel = ~prev;
    end else begin
      sel = r1;
    end
    return sel;
  endfunction

  // Saturating 8-bit increment for the hold counter
  function automatic logic [7:0] hold_inc(input logic [7:0] h);
    logic [7:0] nxt;
    if (h == 8'hFF) begin
      nxt = h;
    end else begin
      nxt = h + 8'd1;
    end
    return nxt;
  endfunction

  // Owner-relative views of the request and read lines
  always_comb begin
    own_req = owner ? req1 : req0;
    oth_req = owner ? req0 : req1;
    own_rd  = owner ? rd_en1 : rd_en0;
  end

  // A cycle in which mem_ready is high completes the read, so it does not
  // block a release.
  assign in_flight  = own_rd & ~mem_ready;
  assign release_ok = ~in_flight &
                      (~own_req | ((hold >= HOLD_LIM) & oth_req));
  assign win        = pick(req0, req1, last);

  // Protocol errors:
  //   - any enable from a requester that does not hold the grant, or
  //   - the owner raising read and write together.
  assign bad = ((rd_en0 | wr_en0) & ~gnt0) |
               ((rd_en1 | wr_en1) & ~gnt1) |
               (gnt0 & rd_en0 & wr_en0) |
               (gnt1 & rd_en1 & wr_en1);

  // Memory-side mux. This is combinational so that enables reach the memory
  // in the same cycle the owner raises them. When the owner raises read and
  // write together, only the write goes through.
  always_comb begin
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    if (gnt0) begin
      mem_addr     = addr0;
      mem_data_in  = wdata0;
      mem_write_en = wr_en0;
      mem_read_en  = rd_en0 & ~wr_en0;
    end else if (gnt1) begin
      mem_addr     = addr1;
      mem_data_in  = wdata1;
      mem_write_en = wr_en1;
      mem_read_en  = rd_en1 & ~wr_en1;
    end
  end

  // The response path adds no latency. Only the owner sees ready.
  assign ready0 = gnt0 & mem_ready;
  assign ready1 = gnt1 & mem_ready;
  assign rdata  = mem_data_out;

  // Arbitration state machine. Grants are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      hold      <= 8'd0;
      violation <= 1'b0;
    end else begin
      if (bad) begin
        violation <= 1'b1;
      end

      case (state)
        IDLE, TURN: begin
          if (req0 | req1) begin
            owner <= win;
            gnt0  <= ~win;
            gnt1  <= win;
            hold  <= 8'd0;
            state <= OWN;
          end else begin
            state <= IDLE;
          end
        end

        OWN: begin
          hold <= hold_inc(hold);
          if (release_ok) begin
            last  <= owner;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            state <= TURN;
          end
        end

        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter with MAX_HOLD = 4.
//
// Each cycle's stimulus is applied to the DUT and to a behavioural model.
// The model's expected outputs for that cycle are pushed to a scoreboard
// queue, and a monitor on the falling edge pops and compares them.
//
// Directed scenarios come first, with extra constant checks. Randomized
// bursts follow; those requesters react to the model's grant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, gnt0, gnt1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              rd_en0, rd_en1, wr_en0, wr_en1;
  logic              ready0, ready1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_en, mem_write_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_ready;
  logic              violation;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .rd_en0      (rd_en0),
    .rd_en1      (rd_en1),
    .wr_en0      (wr_en0),
    .wr_en1      (wr_en1),
    .ready0      (ready0),
    .ready1      (ready1),
    .rdata       (rdata),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready),
    .violation   (violation)
  );

  typedef struct packed {
    logic                   rst;
    logic [1:0]             req;
    logic [1:0]             rd;
    logic [1:0]             wr;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic                   mem_ready;
    logic [DATA_W-1:0]      mem_data_out;
  } stim_t;

  // {gnt0,gnt1,ready0,ready1,mem_read_en,mem_write_en,violation,
  //  mem_addr,mem_data_in,rdata}
  localparam int OW = 7 + ADDR_W + 2 * DATA_W;
  typedef logic [OW-1:0] obs_t;

  obs_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last,
  // how many cycles the current owner has had, and the sticky error flag.
  int    m_own;
  int    m_last;
  int    m_cnt;
  bit    m_viol;

  // Random requester bookkeeping
  int    ops[2];
  bit    rd_pend[2];

  stim_t cur;

  function automatic void model_reset();
    m_own  = -1;
    m_last = 1;
    m_cnt  = 0;
    m_viol = 1'b0;
  endfunction

  function automatic obs_t model_out(input stim_t s);
    logic              g0, g1, re, we, r0, r1;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    g0 = (m_own == 0);
    g1 = (m_own == 1);
    re = 1'b0;
    we = 1'b0;
    a  = '0;
    d  = '0;
    if (m_own >= 0) begin
      we = s.wr[m_own];
      re = s.rd[m_own] && !s.wr[m_own];
      a  = s.addr[m_own];
      d  = s.wdata[m_own];
    end
    r0 = g0 && s.mem_ready;
    r1 = g1 && s.mem_ready;
    return {g0, g1, r0, r1, re, we, m_viol, a, d, s.mem_data_out};
  endfunction

  function automatic void model_step(input stim_t s);
    int o;
    if (s.rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_own != i && (s.rd[i] || s.wr[i])) m_viol = 1'b1;
    end
    if (m_own >= 0) begin
      o = m_own;
      if (s.rd[o] && s.wr[o]) m_viol = 1'b1;
      m_cnt = m_cnt + 1;
      if (!(s.rd[o] && !s.mem_ready) &&
          (!s.req[o] || (m_cnt >= MAX_HOLD && s.req[1-o]))) begin
        // The release cycle is followed by one cycle with no owner
        m_last = o;
        m_own  = -1;
      end
    end else begin
      // Free bus: a lone requester wins; on a tie, the one that did not
      // own the bus last wins
      if (s.req[0] && s.req[1]) begin
        m_own = 1 - m_last;
        m_cnt = 0;
      end else if (s.req[0]) begin
        m_own = 0;
        m_cnt = 0;
      end else if (s.req[1]) begin
        m_own = 1;
        m_cnt = 0;
      end
    end
  endfunction

  task automatic drive(input stim_t s);
    rst          = s.rst;
    req0         = s.req[0];
    req1         = s.req[1];
    rd_en0       = s.rd[0];
    rd_en1       = s.rd[1];
    wr_en0       = s.wr[0];
    wr_en1       = s.wr[1];
    addr0        = s.addr[0];
    addr1        = s.addr[1];
    wdata0       = s.wdata[0];
    wdata1       = s.wdata[1];
    mem_ready    = s.mem_ready;
    mem_data_out = s.mem_data_out;
  endtask

  task automatic cycle(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    cyc = cyc + 1;
    sb.push_back(model_out(s));
    model_step(s);
  endtask

  task automatic dchk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every presented cycle against the scoreboard
  initial begin
    obs_t exp_o;
    obs_t act_o;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_o = sb.pop_front();
        act_o = {gnt0, gnt1, ready0, ready1, mem_read_en, mem_write_en,
                 violation, mem_addr, mem_data_in, rdata};
        tests = tests + 1;
        if (act_o !== exp_o) begin
          fails = fails + 1;
          $display("FAIL scoreboard cycle %0d: got %0h expected %0h",
                   cyc, act_o, exp_o);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    r;
    int    own_now;

    cur = '0;
    cur.rst = 1'b1;
    drive(cur);
    model_reset();
    ops[0] = 0; ops[1] = 0;
    rd_pend[0] = 1'b0; rd_pend[1] = 1'b0;

    // Reset state
    cur.rst = 1'b0;
    cycle(cur); #3;
    dchk("rst_gnt0", 32'(gnt0), 32'd0);
    dchk("rst_gnt1", 32'(gnt1), 32'd0);
    dchk("rst_violation", 32'(violation), 32'd0);

    // Parser only: read 0x10, data 0x41 two cycles after the read starts
    cur.req[0] = 1'b1; cur.addr[0] = 32'h10;
    cycle(cur); #3;
    dchk("parser_gnt0_before", 32'(gnt0), 32'd0);
    cur.rd[0] = 1'b1;
    cycle(cur); #3;
    dchk("parser_gnt0", 32'(gnt0), 32'd1);
    dchk("parser_rd_fwd", 32'(mem_read_en), 32'd1);
    dchk("parser_addr", mem_addr, 32'h10);
    cycle(cur);
    cur.mem_ready = 1'b1; cur.mem_data_out = 8'h41;
    cycle(cur); #3;
    dchk("parser_ready0", 32'(ready0), 32'd1);
    dchk("parser_ready1", 32'(ready1), 32'd0);
    dchk("parser_rdata", 32'(rdata), 32'h41);
    cur.rd[0] = 1'b0; cur.mem_ready = 1'b0;
    cycle(cur);
    cur.req[0] = 1'b0;
    cycle(cur); cycle(cur); cycle(cur);

    // Handover: req0 owns, req1 rises, req0 drops at N
    cur.req[0] = 1'b1;
    cycle(cur); cycle(cur);
    cur.req[1] = 1'b1;
    cycle(cur);
    cur.req[0] = 1'b0;
    cycle(cur);
    cycle(cur); #3;
    dchk("handover_turn_gnt0", 32'(gnt0), 32'd0);
    dchk("handover_turn_gnt1", 32'(gnt1), 32'd0);
    dchk("handover_turn_rd", 32'(mem_read_en), 32'd0);
    dchk("handover_turn_wr", 32'(mem_write_en), 32'd0);
    cur.wr[1] = 1'b1; cur.addr[1] = 32'h20; cur.wdata[1] = 8'h33;
    cycle(cur); #3;
    dchk("handover_gnt1", 32'(gnt1), 32'd1);
    dchk("handover_wr_fwd", 32'(mem_write_en), 32'd1);
    dchk("handover_wdata", 32'(mem_data_in), 32'h33);
    cur.wr[1] = 1'b0; cur.req[1] = 1'b0;
    cycle(cur); cycle(cur); cycle(cur);

    // Preemption: req0 reads continuously, req1 waiting
    cur.req[0] = 1'b1;
    cycle(cur);
    for (int k = 1; k <= 5; k++) begin
      cur.rd[0] = 1'b1; cur.req[1] = 1'b1; cur.addr[0] = 32'h100 + k;
      cur.mem_ready = (k == 2 || k == 5);
      cur.mem_data_out = 8'(8'h70 + k);
      cycle(cur); #3;
      if (k == 4) dchk("preempt_deferred_gnt0", 32'(gnt0), 32'd1);
      if (k == 5) dchk("preempt_ready0", 32'(ready0), 32'd1);
    end
    cur.rd[0] = 1'b0; cur.mem_ready = 1'b0;
    cycle(cur); #3;
    dchk("preempt_turn_gnt0", 32'(gnt0), 32'd0);
    dchk("preempt_turn_gnt1", 32'(gnt1), 32'd0);
    cur.wr[1] = 1'b1; cur.addr[1] = 32'h44;
    cycle(cur); #3;
    dchk("preempt_gnt1", 32'(gnt1), 32'd1);
    cur.wr[1] = 1'b0; cur.req[1] = 1'b0;
    cycle(cur);
    cycle(cur);
    cycle(cur); #3;
    dchk("preempt_regrant_gnt0", 32'(gnt0), 32'd1);
    cur.req[0] = 1'b0;
    cycle(cur); cycle(cur); cycle(cur);

    // Tie after reset, then alternation under preemption
    cur.rst = 1'b1;
    cycle(cur);
    cur.rst = 1'b0; cur.req = 2'b11;
    cycle(cur);
    cycle(cur); #3;
    dchk("tie_gnt0", 32'(gnt0), 32'd1);
    dchk("tie_gnt1", 32'(gnt1), 32'd0);
    for (int k = 2; k <= 4; k++) cycle(cur);
    cycle(cur); #3;
    dchk("tie_turn", 32'({gnt0, gnt1}), 32'd0);
    cycle(cur); #3;
    dchk("tie_alt_gnt1", 32'(gnt1), 32'd1);
    for (int k = 2; k <= 4; k++) cycle(cur);
    cycle(cur);
    cycle(cur); #3;
    dchk("tie_alt_gnt0", 32'(gnt0), 32'd1);
    cur.req = 2'b00;
    cycle(cur); cycle(cur); cycle(cur);

    // Violation: CPU writes while the parser owns the bus
    cur.req[0] = 1'b1;
    cycle(cur); cycle(cur);
    cur.wr[1] = 1'b1; cur.addr[1] = 32'hAA; cur.wdata[1] = 8'h05;
    cycle(cur); #3;
    dchk("viol_wr_blocked", 32'(mem_write_en), 32'd0);
    dchk("viol_not_yet", 32'(violation), 32'd0);
    cur.wr[1] = 1'b0;
    cycle(cur); #3;
    dchk("viol_set", 32'(violation), 32'd1);
    cur.req[0] = 1'b0;
    cycle(cur); cycle(cur); cycle(cur); #3;
    dchk("viol_sticky", 32'(violation), 32'd1);
    cur.rst = 1'b1;
    cycle(cur);
    cur.rst = 1'b0;
    cycle(cur); #3;
    dchk("viol_cleared", 32'(violation), 32'd0);

    // Reset mid-read by the CPU
    cur.req[1] = 1'b1;
    cycle(cur);
    cur.rd[1] = 1'b1; cur.addr[1] = 32'h30;
    cycle(cur); #3;
    dchk("rstrd_gnt1", 32'(gnt1), 32'd1);
    cur.rst = 1'b1;
    cycle(cur);
    cur.rst = 1'b0; cur.rd[1] = 1'b0; cur.req = 2'b11;
    cycle(cur); #3;
    dchk("rstrd_gnt1_low", 32'(gnt1), 32'd0);
    dchk("rstrd_rd_low", 32'(mem_read_en), 32'd0);
    dchk("rstrd_violation", 32'(violation), 32'd0);
    cycle(cur); #3;
    dchk("rstrd_gnt0_first", 32'(gnt0), 32'd1);
    cur = '0;
    cur.rst = 1'b1;
    cycle(cur);

    // Randomized bursts
    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.rst = ($urandom_range(0, 299) == 0);
      s.mem_ready = ($urandom_range(0, 9) < 4);
      s.mem_data_out = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        s.addr[i]  = $urandom;
        s.wdata[i] = 8'($urandom);
        if (ops[i] == 0 && !rd_pend[i] && $urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 3) == 0) ops[i] = int'($urandom_range(6, 12));
          else ops[i] = int'($urandom_range(1, 4));
        end
        s.req[i] = (ops[i] != 0) || rd_pend[i];
        if (m_own == i) begin
          if (rd_pend[i]) begin
            s.rd[i] = 1'b1;
          end else if (ops[i] != 0) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) s.rd[i] = 1'b1;
            else if (r < 75) s.wr[i] = 1'b1;
            else if (r < 77) begin s.rd[i] = 1'b1; s.wr[i] = 1'b1; end
          end
        end else if ($urandom_range(0, 499) == 0) begin
          s.wr[i] = 1'b1;
        end
      end
      own_now = m_own;
      cycle(s);
      for (int i = 0; i < 2; i++) begin
        if (s.rst) begin
          ops[i] = 0;
          rd_pend[i] = 1'b0;
        end else if (own_now == i) begin
          if (s.wr[i]) begin
            if (ops[i] > 0) ops[i] = ops[i] - 1;
          end else if (s.rd[i]) begin
            if (s.mem_ready) begin
              rd_pend[i] = 1'b0;
              if (ops[i] > 0) ops[i] = ops[i] - 1;
            end else begin
              rd_pend[i] = 1'b1;
            end
          end
        end
      end
    end

    cur = '0;
    cycle(cur);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
